// File: rtl/cpu_pkg.sv
// Shared core-wide constants and the fetch-stage state encoding.
package cpu_pkg;

  localparam int unsigned XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

  typedef enum logic [1:0] {
    S_ISSUE,  // request pc_q this cycle
    S_WAIT,   // one live request outstanding
    S_FULL,   // response parked in the skid buffer, no request outstanding
    S_DROP    // one killed request outstanding, its data will be discarded
  } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, pc} buffer that parks a fetch response while ID is stalled.
module fetch_skid_buf #(
  parameter int unsigned XLEN = cpu_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic            clear_i,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            valid_o,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] pc_o
);

  // Clear wins over load so a redirect always empties the buffer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_o <= 1'b0;
      instr_o <= '0;
      pc_o    <= '0;
    end else if (clear_i) begin
      valid_o <= 1'b0;
    end else if (load_i) begin
      valid_o <= 1'b1;
      instr_o <= instr_i;
      pc_o    <= pc_i;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch plus IF/ID register: single outstanding imem request,
// one-entry skid buffer for responses arriving under stall, EX redirects.
module fetch_stage #(
  parameter int unsigned     XLEN      = cpu_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = cpu_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            if_id_valid,
  output logic [31:0]     if_id_instr,
  output logic [XLEN-1:0] if_id_pc
);

  import cpu_pkg::*;

  fetch_state_t    state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] req_pc_q;

  logic            buf_valid;
  logic [31:0]     buf_instr;
  logic [XLEN-1:0] buf_pc;

  logic accept;
  logic issue;
  logic take_rdata;
  logic take_buf;
  logic buf_load;
  logic buf_clear;

  // Decode this cycle's actions; a redirect suppresses all of them.
  always_comb begin
    accept     = !if_id_valid || !stall;
    issue      = 1'b0;
    take_rdata = 1'b0;
    take_buf   = 1'b0;
    buf_load   = 1'b0;
    if (!redirect_valid) begin
      unique case (state_q)
        S_ISSUE: issue = 1'b1;
        S_WAIT: begin
          if (imem_rvalid) begin
            if (accept) begin
              take_rdata = 1'b1;
              issue      = 1'b1;
            end else begin
              buf_load = 1'b1;
            end
          end
        end
        S_FULL: begin
          if (!stall) begin
            take_buf = 1'b1;
            issue    = 1'b1;
          end
        end
        S_DROP: ;
        default: ;
      endcase
    end
    buf_clear = redirect_valid || take_buf;
    imem_req  = rst_n && issue;
    imem_addr = pc_q;
  end

  fetch_skid_buf #(
    .XLEN (XLEN)
  ) u_skid_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (buf_load),
    .clear_i (buf_clear),
    .instr_i (imem_rdata),
    .pc_i    (req_pc_q),
    .valid_o (buf_valid),
    .instr_o (buf_instr),
    .pc_o    (buf_pc)
  );

  // FSM, PC registers and the IF/ID pipeline register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_ISSUE;
      pc_q        <= RESET_PC;
      req_pc_q    <= '0;
      if_id_valid <= 1'b0;
      if_id_instr <= NOP_INSTR;
      if_id_pc    <= '0;
    end else if (redirect_valid) begin
      pc_q        <= {redirect_pc[XLEN-1:2], 2'b00};
      if_id_valid <= 1'b0;
      if_id_instr <= NOP_INSTR;
      // A request still in flight must be drained before refetching.
      if ((state_q == S_WAIT || state_q == S_DROP) && !imem_rvalid) begin
        state_q <= S_DROP;
      end else begin
        state_q <= S_ISSUE;
      end
    end else begin
      if (issue) begin
        req_pc_q <= pc_q;
        pc_q     <= pc_q + XLEN'(4);
      end

      if (take_rdata) begin
        if_id_valid <= 1'b1;
        if_id_instr <= imem_rdata;
        if_id_pc    <= req_pc_q;
      end else if (take_buf && buf_valid) begin
        if_id_valid <= 1'b1;
        if_id_instr <= buf_instr;
        if_id_pc    <= buf_pc;
      end else if (!stall) begin
        if_id_valid <= 1'b0;
        if_id_instr <= NOP_INSTR;
      end

      unique case (state_q)
        S_ISSUE: state_q <= S_WAIT;
        S_WAIT:  if (imem_rvalid && !accept) state_q <= S_FULL;
        S_FULL:  if (!stall) state_q <= S_WAIT;
        S_DROP:  if (imem_rvalid) state_q <= S_ISSUE;
        default: state_q <= S_ISSUE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed walk through the main scenarios, then
// randomized stall/redirect/reset/latency traffic against a program-order model.
module tb_fetch_stage;

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;

  always #5 clk = ~clk;

  fetch_stage #(
    .XLEN      (32),
    .RESET_PC  (RESET_PC),
    .NOP_INSTR (NOP)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .if_id_valid    (if_id_valid),
    .if_id_instr    (if_id_instr),
    .if_id_pc       (if_id_pc)
  );

  int          tests = 0;
  int          fails = 0;
  int unsigned lat = 1;
  int          deliveries = 0;
  int          idle = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_next_pc = '0;

  // Instruction memory contents: a fixed hash of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h4) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: ID must see consecutive words starting at the last
  // reset/redirect target, each exactly once, in order.
  function automatic void model_restart(input logic [31:0] t);
    exp_q.delete();
    model_next_pc = {t[31:2], 2'b00};
  endfunction

  function automatic void model_refill();
    while (exp_q.size() < 4) begin
      exp_q.push_back(exp_t'({model_next_pc, mem_word(model_next_pc)}));
      model_next_pc = model_next_pc + 32'd4;
    end
  endfunction

  // Memory: in-order, one response per request after `lat` cycles.
  initial begin : mem_model
    logic        s_req, s_rv, s_rst, pending;
    logic [31:0] s_addr, paddr;
    int unsigned cnt;
    pending     = 1'b0;
    paddr       = '0;
    cnt         = 0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(negedge clk);
      s_req  = imem_req;
      s_addr = imem_addr;
      s_rv   = imem_rvalid;
      s_rst  = rst_n;
      @(posedge clk);
      #2;
      if (!s_rst) begin
        pending     = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
      end else begin
        if (s_rv) pending = 1'b0;
        if (s_req) begin
          chk("one_outstanding", {31'b0, pending}, 32'h0);
          chk("addr_aligned", {30'b0, s_addr[1:0]}, 32'h0);
          pending = 1'b1;
          paddr   = s_addr;
          cnt     = lat - 1;
        end
        if (pending && cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(paddr);
        end else begin
          if (pending) cnt--;
          imem_rvalid = 1'b0;
          imem_rdata  = $urandom;
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever a new instruction reaches ID.
  initial begin : monitor
    logic        p_rst, p_valid, p_stall, p_redir;
    logic [31:0] p_instr, p_pc;
    exp_t        e;
    p_rst   = 1'b0;
    p_valid = 1'b0;
    p_stall = 1'b0;
    p_redir = 1'b0;
    p_instr = '0;
    p_pc    = '0;
    forever begin
      @(negedge clk);
      if (!p_rst) begin
        chk("reset_valid", {31'b0, if_id_valid}, 32'h0);
        chk("reset_instr", if_id_instr, NOP);
        chk("reset_pc", if_id_pc, 32'h0);
      end else begin
        if (p_valid && p_stall && !p_redir) begin
          chk("stall_hold_valid", {31'b0, if_id_valid}, 32'h1);
          chk("stall_hold_instr", if_id_instr, p_instr);
          chk("stall_hold_pc", if_id_pc, p_pc);
        end
        if (p_redir) chk("redirect_kill", {31'b0, if_id_valid}, 32'h0);
      end
      if (!rst_n) chk("no_req_in_reset", {31'b0, imem_req}, 32'h0);
      if (!if_id_valid) chk("nop_when_invalid", if_id_instr, NOP);

      if (if_id_valid && (!p_valid || !p_stall)) begin
        idle = 0;
        deliveries++;
        e = exp_q.pop_front();
        chk("deliver_pc", if_id_pc, e.pc);
        chk("deliver_instr", if_id_instr, e.instr);
      end else begin
        idle++;
      end

      if (!rst_n) begin
        model_restart(RESET_PC);
        idle = 0;
      end else if (redirect_valid) begin
        model_restart(redirect_pc);
        idle = 0;
      end
      model_refill();

      if (idle > 60) begin
        chk("progress_watchdog", idle, 32'h0);
        idle = 0;
      end

      p_rst   = rst_n;
      p_valid = if_id_valid;
      p_stall = stall;
      p_redir = redirect_valid;
      p_instr = if_id_instr;
      p_pc    = if_id_pc;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    rst_n          = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    lat            = 1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Streaming at latency 1: one request per cycle, IF/ID two cycles behind.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stream_req", {31'b0, imem_req}, 32'h1);
      chk("stream_addr", imem_addr, 32'(4 * i));
      if (i >= 2) begin
        chk("stream_valid", {31'b0, if_id_valid}, 32'h1);
        chk("stream_if_pc", if_id_pc, 32'(4 * (i - 2)));
      end
      step();
    end

    // Reset, then park 0x4 in the skid buffer behind a stall.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_addr", imem_addr, RESET_PC);
    step();
    step();                                  // R2: response for 0x4 arrives
    stall = 1'b1;
    @(negedge clk);
    chk("skid_no_req", {31'b0, imem_req}, 32'h0);
    chk("skid_if_pc", if_id_pc, 32'h0);
    step();                                  // R3: still stalled
    @(negedge clk);
    chk("skid_hold_no_req", {31'b0, imem_req}, 32'h0);
    step();                                  // R4: stall drops
    stall = 1'b0;
    lat   = 3;
    @(negedge clk);
    chk("unstall_req", {31'b0, imem_req}, 32'h1);
    chk("unstall_addr", imem_addr, 32'h8);
    step();                                  // R5: 0x8 outstanding, redirect
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    @(negedge clk);
    chk("buf_if_pc", if_id_pc, 32'h4);
    chk("buf_if_instr", if_id_instr, 32'h0050_0093);
    chk("redirect_no_req", {31'b0, imem_req}, 32'h0);
    step();                                  // R6: S_DROP
    redirect_valid = 1'b0;
    lat            = 1;
    @(negedge clk);
    chk("drop_no_req", {31'b0, imem_req}, 32'h0);
    step();                                  // R7: stale 0x8 response
    @(negedge clk);
    chk("drop_stale_no_req", {31'b0, imem_req}, 32'h0);
    chk("drop_stale_invalid", {31'b0, if_id_valid}, 32'h0);
    step();                                  // R8
    @(negedge clk);
    chk("refetch_addr", imem_addr, 32'h0000_0100);
    chk("refetch_req", {31'b0, imem_req}, 32'h1);
    step();
    step();                                  // R10: 0x100 valid in IF/ID
    stall          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFE;
    @(negedge clk);
    chk("target_if_pc", if_id_pc, 32'h0000_0100);
    step();                                  // R11
    stall          = 1'b0;
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("override_stall_kill", {31'b0, if_id_valid}, 32'h0);
    chk("wrap_first_addr", imem_addr, 32'hFFFF_FFFC);
    step();                                  // R12
    @(negedge clk);
    chk("wrap_second_addr", imem_addr, 32'h0000_0000);
    step();                                  // R13
    lat = 3;
    @(negedge clk);
    chk("wrap_if_pc", if_id_pc, 32'hFFFF_FFFC);
    step();                                  // R14: reset with request in flight
    rst_n = 1'b0;
    step();                                  // R15
    rst_n = 1'b1;
    lat   = 1;
    @(negedge clk);
    chk("midreq_reset_req", {31'b0, imem_req}, 32'h1);
    chk("midreq_reset_addr", imem_addr, RESET_PC);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      step();
      rst_n          = ($urandom_range(0, 199) != 0);
      stall          = ($urandom_range(0, 99) < 30);
      redirect_valid = ($urandom_range(0, 99) < 4);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                   : $urandom;
      lat            = $urandom_range(1, 3);
    end
    step();
    rst_n          = 1'b1;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    repeat (10) step();
    chk("enough_deliveries", {31'b0, (deliveries >= 500)}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
